// File: rtl/hybrid_montgomery.sv
`default_nettype none
// ============================================================================
// Module   : hybrid_montgomery
// Purpose  : Iterative Montgomery modular multiplier, Y = A*B*2^-N mod M.
//            Radix-2 Montgomery reduction with W steps unrolled per clock, so
//            one operation takes N/W compute cycles plus one reduction cycle.
// Ports    : clk   - clock, rising edge
//            rst   - synchronous reset, active low
//            start - request pulse, only honoured while idle
//            A, B  - operands (N bits), expected to be below the modulus
//            M     - odd modulus (N bits); zero selects the fallback P
//            done  - one-cycle pulse, Y valid
//            Y     - result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module hybrid_montgomery #(
    parameter int N = 32,
    parameter int W = 8,
    parameter int P = 17
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    output logic         done,
    output logic [N-1:0] Y
);

    localparam int             STEPS    = N / W;
    localparam int             CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);
    localparam logic [N-1:0]   P_VEC    = N'(P);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [N-1:0]       r_a;
    logic [N-1:0]       r_b;
    logic [N-1:0]       r_m;
    logic [N+1:0]       r_t;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic [N-1:0]       r_y;

    logic [N+1:0]       w_t_step;
    logic               w_t_ge_m;
    logic [N-1:0]       w_y_final;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = S_FINAL;
                end
            end
            S_FINAL: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // W unrolled radix-2 Montgomery steps. The accumulator stays below
    // 2*M, so T + B + M < 4*M fits in the N+2 bit accumulator.
    // ------------------------------------------------------------------
    always_comb begin
        w_t_step = r_t;
        for (int i = 0; i < W; i++) begin
            if (r_a[i]) begin
                w_t_step = w_t_step + {2'b00, r_b};
            end
            if (w_t_step[0]) begin
                w_t_step = w_t_step + {2'b00, r_m};
            end
            w_t_step = w_t_step >> 1;
        end
    end

    // Final conditional subtract. The reduced value is below M, so the
    // subtraction only needs the low N bits; the compare uses all of T.
    assign w_t_ge_m  = (r_t >= {2'b00, r_m});
    assign w_y_final = w_t_ge_m ? (r_t[N-1:0] - r_m) : r_t[N-1:0];

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_m    <= '0;
            r_t    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_y    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_m   <= (M == '0) ? P_VEC : M;
                        r_t   <= '0;
                        r_cnt <= '0;
                    end
                end
                S_CALC: begin
                    r_t   <= w_t_step;
                    // Consumed multiplier bits are shifted out, LSB first.
                    r_a   <= r_a >> W;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_FINAL: begin
                    r_y    <= w_y_final;
                    r_done <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign done = r_done;
    assign Y    = r_y;

endmodule
`default_nettype wire

// File: tb/tb_hybrid_montgomery.sv
`default_nettype none
// ============================================================================
// Module   : tb_hybrid_montgomery
// Purpose  : Self-checking bench for hybrid_montgomery. Expected results come
//            from a modular-arithmetic reference (halving modulo M, N times).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hybrid_montgomery;

    localparam int N   = 32;
    localparam int W   = 8;
    localparam int P   = 17;
    localparam int LAT = N / W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] m;
    logic         done;
    logic [N-1:0] y;

    int checks = 0;
    int errors = 0;

    hybrid_montgomery #(.N(N), .W(W), .P(P)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .M     (m),
        .done  (done),
        .Y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A*B*2^-N mod M: reduce the product, then divide by two N times mod M.
    function automatic logic [N-1:0] mont_ref(input logic [N-1:0] fa,
                                              input logic [N-1:0] fb,
                                              input logic [N-1:0] fm);
        logic [63:0] mm;
        logic [63:0] v;
        mm = (fm == '0) ? 64'(P) : {32'b0, fm};
        v  = (({32'b0, fa} % mm) * ({32'b0, fb} % mm)) % mm;
        for (int i = 0; i < N; i++) begin
            v = v[0] ? ((v + mm) >> 1) : (v >> 1);
        end
        return v[N-1:0];
    endfunction

    // Issues one operation and watches a fixed window after the start edge.
    // With disturb set, start is re-asserted and the inputs scrambled while
    // the operation is computing.
    task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                          input logic [N-1:0] im, input bit disturb,
                          output logic [N-1:0] y_done, output logic [N-1:0] y_end,
                          output int lat, output int ndone);
        @(negedge clk);
        a = ia; b = ib; m = im; start = 1'b1;
        @(posedge clk);
        lat    = -1;
        ndone  = 0;
        y_done = '0;
        for (int c = 1; c <= LAT + 3; c++) begin
            @(negedge clk);
            if (disturb && c <= 3) begin
                start = 1'b1;
                a = $urandom; b = $urandom; m = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                ndone++;
                if (lat < 0) begin
                    lat    = c;
                    y_done = y;
                end
            end
        end
        y_end = y;
    endtask

    // Counts cycles after a start edge until done, bounded.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= LAT + 4; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = c;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; a = '0; b = '0; m = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL reset_done: got %b want 0", done);
        end
        checks++;
        if (y !== '0) begin
            errors++; $display("FAIL reset_y: got %0d want 0", y);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [5] = '{32'd17, 32'd123, 32'd3, 32'd1, 32'd0};
        logic [N-1:0] tb_ [5] = '{32'd19, 32'd456, 32'd5, 32'd12, 32'd22};
        logic [N-1:0] tm [5] = '{32'd23, 32'd789, 32'd0, 32'd23, 32'd23};
        logic [N-1:0] te [5] = '{32'd2, 32'd675, 32'd15, 32'd1, 32'd0};
        logic [N-1:0] yd, ye;
        int lat, nd;
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb_[i], tm[i], 1'b0, yd, ye, lat, nd);
            checks++;
            if (yd !== te[i]) begin
                errors++; $display("FAIL directed_y[%0d]: got %0d want %0d", i, yd, te[i]);
            end
            checks++;
            if (lat != LAT) begin
                errors++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if (nd != 1) begin
                errors++; $display("FAIL directed_done_count[%0d]: got %0d want 1", i, nd);
            end
            checks++;
            if (ye !== te[i]) begin
                errors++; $display("FAIL directed_y_hold[%0d]: got %0d want %0d", i, ye, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] ra, rb, rm, exp_y, yd, ye;
        int lat, nd;
        for (int i = 0; i < 24; i++) begin
            if (i % 4 == 3) begin
                rm = '0;
                ra = $urandom_range(P - 1, 0);
                rb = $urandom_range(P - 1, 0);
            end else begin
                rm = $urandom | 32'd1;
                ra = $urandom % rm;
                rb = $urandom % rm;
            end
            exp_y = mont_ref(ra, rb, rm);
            run_op(ra, rb, rm, 1'b0, yd, ye, lat, nd);
            checks++;
            if (yd !== exp_y || lat != LAT || nd != 1) begin
                errors++;
                $display("FAIL random[%0d] a=%0d b=%0d m=%0d: got y=%0d lat=%0d dones=%0d want y=%0d lat=%0d dones=1",
                         i, ra, rb, rm, yd, lat, nd, exp_y, LAT);
            end
        end
    endtask

    task automatic test_protocol();
        logic [N-1:0] yd, ye;
        int lat, nd;
        run_op(32'd17, 32'd19, 32'd23, 1'b1, yd, ye, lat, nd);
        checks++;
        if (yd !== 32'd2) begin
            errors++; $display("FAIL protocol_y: got %0d want 2", yd);
        end
        checks++;
        if (lat != LAT) begin
            errors++; $display("FAIL protocol_latency: got %0d want %0d", lat, LAT);
        end
        checks++;
        if (nd != 1) begin
            errors++; $display("FAIL protocol_done_count: got %0d want 1", nd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [N-1:0] a2, b2, m2;
        @(negedge clk);
        a = 32'd123; b = 32'd456; m = 32'd789; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != LAT || y !== 32'd675) begin
            errors++; $display("FAIL b2b_first: got lat=%0d y=%0d want lat=%0d y=675", lat, y, LAT);
        end
        // Second request raised during the done cycle.
        m2 = $urandom | 32'd1;
        a2 = $urandom % m2;
        b2 = $urandom % m2;
        a = a2; b = b2; m = m2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        checks++;
        if (lat != LAT || y !== mont_ref(a2, b2, m2)) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d y=%0d want lat=%0d y=%0d", lat, y, LAT, mont_ref(a2, b2, m2));
        end
    endtask

    task automatic test_reset_mid();
        int nd;
        logic [N-1:0] yd, ye;
        int lat;
        @(negedge clk);
        a = 32'd123; b = 32'd456; m = 32'd789; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || y !== '0) begin
            errors++; $display("FAIL reset_mid: got done=%b y=%0d want done=0 y=0", done, y);
        end
        @(negedge clk);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d dones want 0", nd);
        end
        run_op(32'd17, 32'd19, 32'd23, 1'b0, yd, ye, lat, nd);
        checks++;
        if (yd !== 32'd2 || lat != LAT || nd != 1) begin
            errors++; $display("FAIL reset_mid_restart: got y=%0d lat=%0d dones=%0d want y=2 lat=%0d dones=1",
                               yd, lat, nd, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_protocol();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
